// File: rtl/spec_regfile.sv
// spec_regfile: register file with rename status tags for a Tomasulo-style
// core. It keeps live register values and per-register producer tags, captures
// results broadcast on the common data bus (CDB), and holds a FIFO of branch
// checkpoints that can restore the live file in a single edge on a mispredict.
//
// Ports
//   clk_i, reset_i             clock; synchronous active-high reset
//   cdb_valid_i/tag_i/val_i    per-channel CDB broadcast (tag 0 never matches)
//   rd_addr1_i/2_i -> rd_data1_o/2_o        live register values (r0 reads 0)
//   tag_rd_idx1_i/2_i -> tag1_o/2_o          pending producer tag (0 = ready)
//   tag_wr_en_i/idx_i/tag_i    rename a destination register to a new producer
//   ckpt_save_i                take a checkpoint (branch issued)
//   resolve_valid_i/mispred_i  oldest outstanding branch resolved
//   ckpt_count_o, ckpt_full_o  outstanding checkpoints, registered
//
// Handshake: there is no backpressure on the CDB or rename port; every valid
// input is consumed on the edge it is presented. Issue logic must hold off
// ckpt_save_i while ckpt_full_o is high (a save while full is dropped unless
// a correct resolve frees a slot in the same cycle).
module spec_regfile #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_CDB  = 2,
  parameter int NUM_CKPT = 2,
  localparam int AW    = $clog2(NUM_REGS),
  localparam int CNT_W = $clog2(NUM_CKPT) + 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NUM_CDB-1:0]          cdb_valid_i,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag_i,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_val_i,
  input  logic [AW-1:0]               rd_addr1_i,
  input  logic [AW-1:0]               rd_addr2_i,
  output logic [DATA_W-1:0]           rd_data1_o,
  output logic [DATA_W-1:0]           rd_data2_o,
  input  logic [AW-1:0]               tag_rd_idx1_i,
  input  logic [AW-1:0]               tag_rd_idx2_i,
  output logic [TAG_W-1:0]            tag1_o,
  output logic [TAG_W-1:0]            tag2_o,
  input  logic                        tag_wr_en_i,
  input  logic [AW-1:0]               tag_wr_idx_i,
  input  logic [TAG_W-1:0]            tag_wr_tag_i,
  input  logic                        ckpt_save_i,
  input  logic                        resolve_valid_i,
  input  logic                        resolve_mispred_i,
  output logic [CNT_W-1:0]            ckpt_count_o,
  output logic                        ckpt_full_o
);

  localparam int PTR_W = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

  logic [DATA_W-1:0] live_val_q [NUM_REGS];
  logic [DATA_W-1:0] live_val_d [NUM_REGS];
  logic [TAG_W-1:0]  live_tag_q [NUM_REGS];
  logic [TAG_W-1:0]  live_tag_d [NUM_REGS];

  logic [DATA_W-1:0] snap_val_q [NUM_CKPT][NUM_REGS];
  logic [DATA_W-1:0] snap_val_s [NUM_CKPT][NUM_REGS];
  logic [DATA_W-1:0] snap_val_d [NUM_CKPT][NUM_REGS];
  logic [TAG_W-1:0]  snap_tag_q [NUM_CKPT][NUM_REGS];
  logic [TAG_W-1:0]  snap_tag_s [NUM_CKPT][NUM_REGS];
  logic [TAG_W-1:0]  snap_tag_d [NUM_CKPT][NUM_REGS];

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic full, mispred, correct, save, tag_we;

  // Returns {hit, value}. Scanning from the highest channel down lets the
  // lowest-index matching channel overwrite the result last, so it wins.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]          t,
    input logic [NUM_CDB-1:0]        v,
    input logic [NUM_CDB*TAG_W-1:0]  tg,
    input logic [NUM_CDB*DATA_W-1:0] vl
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (v[c] && (t != '0) && (tg[c*TAG_W +: TAG_W] == t)) begin
        res = {1'b1, vl[c*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_CKPT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(NUM_CKPT));
  assign mispred = resolve_valid_i && resolve_mispred_i && (count_q != '0);
  assign correct = resolve_valid_i && !resolve_mispred_i && (count_q != '0);
  // A correct resolve frees the head slot on the same edge, so a save may
  // proceed even when the FIFO is currently full.
  assign save    = ckpt_save_i && (!full || correct) && !mispred;
  assign tag_we  = tag_wr_en_i && (tag_wr_idx_i != '0) && (tag_wr_tag_i != '0) && !mispred;

  // Register/tag next state for the live file and all snapshots.
  always_comb begin
    logic [DATA_W:0] hit;
    hit        = '0;
    snap_val_s = snap_val_q;
    snap_tag_s = snap_tag_q;
    for (int k = 0; k < NUM_CKPT; k++) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        hit = cdb_lookup(snap_tag_q[k][i], cdb_valid_i, cdb_tag_i, cdb_val_i);
        if (hit[DATA_W]) begin
          snap_val_s[k][i] = hit[DATA_W-1:0];
          snap_tag_s[k][i] = '0;
        end
      end
    end

    if (mispred) begin
      // The snooped head snapshot already has this cycle's CDB results merged.
      live_val_d = snap_val_s[head_q];
      live_tag_d = snap_tag_s[head_q];
    end else begin
      live_val_d = live_val_q;
      live_tag_d = live_tag_q;
      for (int i = 1; i < NUM_REGS; i++) begin
        hit = cdb_lookup(live_tag_q[i], cdb_valid_i, cdb_tag_i, cdb_val_i);
        if (hit[DATA_W]) begin
          live_val_d[i] = hit[DATA_W-1:0];
          live_tag_d[i] = '0;
        end
      end
      // Rename wins over a same-cycle CDB clear; the value is still captured.
      if (tag_we) live_tag_d[tag_wr_idx_i] = tag_wr_tag_i;
    end
    live_val_d[0] = '0;
    live_tag_d[0] = '0;

    snap_val_d = snap_val_s;
    snap_tag_d = snap_tag_s;
    if (save) begin
      snap_val_d[tail_q] = live_val_d;
      snap_tag_d[tail_q] = live_tag_d;
    end
  end

  // Checkpoint FIFO pointers and occupancy.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mispred) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (correct) head_d = ptr_inc(head_q);
      if (save)    tail_d = ptr_inc(tail_q);
      if (save && !correct)      count_d = count_q + CNT_W'(1);
      else if (correct && !save) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live_tag_q[i] <= '0;
        for (int k = 0; k < NUM_CKPT; k++) snap_tag_q[k][i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      live_tag_q <= live_tag_d;
      snap_tag_q <= snap_tag_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Register values survive reset; only r0 is forced to zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      live_val_q[0] <= '0;
    end else begin
      live_val_q <= live_val_d;
      snap_val_q <= snap_val_d;
    end
  end

  assign rd_data1_o = (rd_addr1_i == '0) ? '0 : live_val_q[rd_addr1_i];
  assign rd_data2_o = (rd_addr2_i == '0) ? '0 : live_val_q[rd_addr2_i];

  assign tag1_o = (tag_we && (tag_wr_idx_i == tag_rd_idx1_i)) ? tag_wr_tag_i
                                                               : live_tag_q[tag_rd_idx1_i];
  assign tag2_o = (tag_we && (tag_wr_idx_i == tag_rd_idx2_i)) ? tag_wr_tag_i
                                                               : live_tag_q[tag_rd_idx2_i];

  assign ckpt_count_o = count_q;
  assign ckpt_full_o  = full;

endmodule

// File: tb/tb_spec_regfile.sv
module tb_spec_regfile;

  logic        clk;
  logic        reset;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_val;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic [4:0]  tag_rd_idx1, tag_rd_idx2;
  logic [3:0]  tag1, tag2;
  logic        tag_wr_en;
  logic [4:0]  tag_wr_idx;
  logic [3:0]  tag_wr_tag;
  logic        ckpt_save;
  logic        resolve_valid;
  logic        resolve_mispred;
  logic [1:0]  ckpt_count;
  logic        ckpt_full;

  int pass_cnt = 0;
  int total_cnt = 0;

  spec_regfile dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .cdb_valid_i       (cdb_valid),
    .cdb_tag_i         (cdb_tag),
    .cdb_val_i         (cdb_val),
    .rd_addr1_i        (rd_addr1),
    .rd_addr2_i        (rd_addr2),
    .rd_data1_o        (rd_data1),
    .rd_data2_o        (rd_data2),
    .tag_rd_idx1_i     (tag_rd_idx1),
    .tag_rd_idx2_i     (tag_rd_idx2),
    .tag1_o            (tag1),
    .tag2_o            (tag2),
    .tag_wr_en_i       (tag_wr_en),
    .tag_wr_idx_i      (tag_wr_idx),
    .tag_wr_tag_i      (tag_wr_tag),
    .ckpt_save_i       (ckpt_save),
    .resolve_valid_i   (resolve_valid),
    .resolve_mispred_i (resolve_mispred),
    .ckpt_count_o      (ckpt_count),
    .ckpt_full_o       (ckpt_full)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cdb_valid       = '0;
    cdb_tag         = '0;
    cdb_val         = '0;
    tag_wr_en       = 1'b0;
    tag_wr_idx      = '0;
    tag_wr_tag      = '0;
    ckpt_save       = 1'b0;
    resolve_valid   = 1'b0;
    resolve_mispred = 1'b0;
  endtask

  task automatic rename(input logic [4:0] idx, input logic [3:0] t);
    tag_wr_en  = 1'b1;
    tag_wr_idx = idx;
    tag_wr_tag = t;
  endtask

  task automatic bcast(input int ch, input logic [3:0] t, input logic [31:0] v);
    cdb_valid[ch]         = 1'b1;
    cdb_tag[ch*4 +: 4]    = t;
    cdb_val[ch*32 +: 32]  = v;
  endtask

  // Put a known value into a register via rename + broadcast on channel 0.
  task automatic write_reg(input logic [4:0] idx, input logic [3:0] t, input logic [31:0] v);
    idle();
    rename(idx, t);
    step();
    idle();
    bcast(0, t, v);
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rd_addr1 = '0; rd_addr2 = '0; tag_rd_idx1 = 5'd5; tag_rd_idx2 = '0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    total_cnt++; if (ckpt_count !== 2'd0) $display("FAIL reset_count got %0d want 0", ckpt_count); else pass_cnt++;
    total_cnt++; if (ckpt_full !== 1'b0) $display("FAIL reset_full got %0b want 0", ckpt_full); else pass_cnt++;
    total_cnt++; if (tag1 !== 4'd0) $display("FAIL reset_tag_r5 got %0h want 0", tag1); else pass_cnt++;
    total_cnt++; if (rd_data1 !== 32'd0) $display("FAIL reset_r0 got %0h want 0", rd_data1); else pass_cnt++;
  endtask

  task automatic test_rename_cdb();
    write_reg(5'd5, 4'd1, 32'h0000_1111);
    rd_addr1 = 5'd5; tag_rd_idx1 = 5'd5;
    rename(5'd5, 4'd3);
    step(); idle();
    total_cnt++; if (tag1 !== 4'd3) $display("FAIL rename_tag got %0h want 3", tag1); else pass_cnt++;
    bcast(1, 4'd3, 32'hDEAD_BEEF);
    #1;
    total_cnt++; if (rd_data1 !== 32'h0000_1111) $display("FAIL no_bypass_data got %0h want 1111", rd_data1); else pass_cnt++;
    total_cnt++; if (tag1 !== 4'd3) $display("FAIL no_bypass_tag got %0h want 3", tag1); else pass_cnt++;
    step(); idle();
    total_cnt++; if (tag1 !== 4'd0) $display("FAIL cdb_clear_tag got %0h want 0", tag1); else pass_cnt++;
    total_cnt++; if (rd_data1 !== 32'hDEAD_BEEF) $display("FAIL cdb_data got %0h want deadbeef", rd_data1); else pass_cnt++;
  endtask

  task automatic test_same_cycle_tag();
    idle();
    tag_rd_idx1 = 5'd7; tag_rd_idx2 = 5'd7;
    rename(5'd7, 4'd4);
    #1;
    total_cnt++; if (tag1 !== 4'd4) $display("FAIL tag_fwd1 got %0h want 4", tag1); else pass_cnt++;
    total_cnt++; if (tag2 !== 4'd4) $display("FAIL tag_fwd2 got %0h want 4", tag2); else pass_cnt++;
    step(); idle();
    total_cnt++; if (tag1 !== 4'd4) $display("FAIL tag_held got %0h want 4", tag1); else pass_cnt++;
    tag_rd_idx1 = 5'd0;
    rename(5'd0, 4'd9);
    #1;
    total_cnt++; if (tag1 !== 4'd0) $display("FAIL r0_tag_comb got %0h want 0", tag1); else pass_cnt++;
    step(); idle();
    total_cnt++; if (tag1 !== 4'd0) $display("FAIL r0_tag_reg got %0h want 0", tag1); else pass_cnt++;
    bcast(0, 4'd4, 32'h0);
    step(); idle();
    tag_rd_idx1 = 5'd7;
    #1;
    total_cnt++; if (tag1 !== 4'd0) $display("FAIL r7_clear got %0h want 0", tag1); else pass_cnt++;
  endtask

  task automatic test_mispredict_restore();
    write_reg(5'd2, 4'd1, 32'h10);
    rd_addr1 = 5'd2; tag_rd_idx1 = 5'd2;
    ckpt_save = 1'b1;
    step(); idle();
    total_cnt++; if (ckpt_count !== 2'd1) $display("FAIL save_count got %0d want 1", ckpt_count); else pass_cnt++;
    rename(5'd2, 4'd5);
    step(); idle();
    bcast(0, 4'd5, 32'h99);
    step(); idle();
    total_cnt++; if (rd_data1 !== 32'h99) $display("FAIL spec_value got %0h want 99", rd_data1); else pass_cnt++;
    resolve_valid = 1'b1; resolve_mispred = 1'b1;
    step(); idle();
    total_cnt++; if (rd_data1 !== 32'h10) $display("FAIL restore_value got %0h want 10", rd_data1); else pass_cnt++;
    total_cnt++; if (tag1 !== 4'd0) $display("FAIL restore_tag got %0h want 0", tag1); else pass_cnt++;
    total_cnt++; if (ckpt_count !== 2'd0) $display("FAIL restore_count got %0d want 0", ckpt_count); else pass_cnt++;
  endtask

  task automatic test_mispredict_cdb_merge();
    idle();
    rename(5'd3, 4'd6);
    step(); idle();
    ckpt_save = 1'b1;
    step(); idle();
    resolve_valid = 1'b1; resolve_mispred = 1'b1;
    bcast(0, 4'd6, 32'h55);
    ckpt_save = 1'b1;
    rename(5'd9, 4'd7);
    step(); idle();
    rd_addr1 = 5'd3; tag_rd_idx1 = 5'd3; tag_rd_idx2 = 5'd9;
    #1;
    total_cnt++; if (rd_data1 !== 32'h55) $display("FAIL merge_value got %0h want 55", rd_data1); else pass_cnt++;
    total_cnt++; if (tag1 !== 4'd0) $display("FAIL merge_tag got %0h want 0", tag1); else pass_cnt++;
    total_cnt++; if (tag2 !== 4'd0) $display("FAIL mispred_rename_ignored got %0h want 0", tag2); else pass_cnt++;
    total_cnt++; if (ckpt_count !== 2'd0) $display("FAIL mispred_save_ignored got %0d want 0", ckpt_count); else pass_cnt++;
  endtask

  task automatic test_snapshot_snoop();
    idle();
    rename(5'd8, 4'd10);
    step(); idle();
    ckpt_save = 1'b1;
    step(); idle();
    bcast(0, 4'd10, 32'h77);
    step(); idle();
    rename(5'd8, 4'd11);
    step(); idle();
    resolve_valid = 1'b1; resolve_mispred = 1'b1;
    step(); idle();
    rd_addr1 = 5'd8; tag_rd_idx1 = 5'd8;
    #1;
    total_cnt++; if (rd_data1 !== 32'h77) $display("FAIL snoop_value got %0h want 77", rd_data1); else pass_cnt++;
    total_cnt++; if (tag1 !== 4'd0) $display("FAIL snoop_tag got %0h want 0", tag1); else pass_cnt++;
  endtask

  task automatic test_rename_over_cdb();
    idle();
    rename(5'd12, 4'd12);
    step(); idle();
    bcast(0, 4'd12, 32'h3C);
    rename(5'd12, 4'd13);
    step(); idle();
    rd_addr2 = 5'd12; tag_rd_idx2 = 5'd12;
    #1;
    total_cnt++; if (rd_data2 !== 32'h3C) $display("FAIL override_value got %0h want 3c", rd_data2); else pass_cnt++;
    total_cnt++; if (tag2 !== 4'd13) $display("FAIL override_tag got %0h want d", tag2); else pass_cnt++;
    bcast(1, 4'd13, 32'h4D);
    step(); idle();
    total_cnt++; if (rd_data2 !== 32'h4D) $display("FAIL ch1_value got %0h want 4d", rd_data2); else pass_cnt++;
  endtask

  task automatic test_back_to_back_ckpt();
    idle();
    ckpt_save = 1'b1;
    step();
    total_cnt++; if (ckpt_full !== 1'b0) $display("FAIL one_full got %0b want 0", ckpt_full); else pass_cnt++;
    step();
    total_cnt++; if (ckpt_count !== 2'd2) $display("FAIL two_count got %0d want 2", ckpt_count); else pass_cnt++;
    total_cnt++; if (ckpt_full !== 1'b1) $display("FAIL two_full got %0b want 1", ckpt_full); else pass_cnt++;
    step();
    total_cnt++; if (ckpt_count !== 2'd2) $display("FAIL full_save_ignored got %0d want 2", ckpt_count); else pass_cnt++;
    resolve_valid = 1'b1;
    step();
    total_cnt++; if (ckpt_count !== 2'd2) $display("FAIL resolve_save_count got %0d want 2", ckpt_count); else pass_cnt++;
    ckpt_save = 1'b0;
    step();
    total_cnt++; if (ckpt_count !== 2'd1) $display("FAIL resolve_dec got %0d want 1", ckpt_count); else pass_cnt++;
    total_cnt++; if (ckpt_full !== 1'b0) $display("FAIL resolve_full got %0b want 0", ckpt_full); else pass_cnt++;
    step();
    total_cnt++; if (ckpt_count !== 2'd0) $display("FAIL resolve_empty got %0d want 0", ckpt_count); else pass_cnt++;
    step();
    total_cnt++; if (ckpt_count !== 2'd0) $display("FAIL empty_resolve_ignored got %0d want 0", ckpt_count); else pass_cnt++;
    // A mispredict with nothing outstanding must not block a rename.
    resolve_mispred = 1'b1;
    rename(5'd13, 4'd14);
    step(); idle();
    tag_rd_idx1 = 5'd13;
    #1;
    total_cnt++; if (tag1 !== 4'd14) $display("FAIL empty_mispred_rename got %0h want e", tag1); else pass_cnt++;
    bcast(0, 4'd14, 32'h0);
    step(); idle();
  endtask

  task automatic test_priority_and_reset();
    write_reg(5'd6, 4'd1, 32'h66);
    rename(5'd4, 4'd2);
    step(); idle();
    bcast(0, 4'd2, 32'hA);
    bcast(1, 4'd2, 32'hB);
    step(); idle();
    rd_addr1 = 5'd4; rd_addr2 = 5'd6;
    #1;
    total_cnt++; if (rd_data1 !== 32'hA) $display("FAIL cdb_priority got %0h want a", rd_data1); else pass_cnt++;
    rename(5'd6, 4'd8);
    step(); idle();
    ckpt_save = 1'b1;
    step(); idle();
    reset = 1'b1;
    ckpt_save = 1'b1;
    rename(5'd6, 4'd9);
    bcast(0, 4'd8, 32'h42);
    step(); idle();
    reset = 1'b0;
    tag_rd_idx1 = 5'd6;
    #1;
    total_cnt++; if (ckpt_count !== 2'd0) $display("FAIL midspec_reset_count got %0d want 0", ckpt_count); else pass_cnt++;
    total_cnt++; if (ckpt_full !== 1'b0) $display("FAIL midspec_reset_full got %0b want 0", ckpt_full); else pass_cnt++;
    total_cnt++; if (tag1 !== 4'd0) $display("FAIL midspec_reset_tag got %0h want 0", tag1); else pass_cnt++;
    total_cnt++; if (rd_data2 !== 32'h66) $display("FAIL reset_keeps_r6 got %0h want 66", rd_data2); else pass_cnt++;
    total_cnt++; if (rd_data1 !== 32'hA) $display("FAIL reset_keeps_r4 got %0h want a", rd_data1); else pass_cnt++;
    ckpt_save = 1'b1;
    step(); idle();
    total_cnt++; if (ckpt_count !== 2'd1) $display("FAIL post_reset_save got %0d want 1", ckpt_count); else pass_cnt++;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; tag_rd_idx1 = '0; tag_rd_idx2 = '0;
    test_reset();
    test_rename_cdb();
    test_same_cycle_tag();
    test_mispredict_restore();
    test_mispredict_cdb_merge();
    test_snapshot_snoop();
    test_rename_over_cdb();
    test_back_to_back_ckpt();
    test_priority_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
